// File: rtl/intersection_scheduler.sv
// Two-road traffic-light scheduler with demand-driven greens, fixed yellow/all-red
// clearance and a pedestrian walk phase inserted after an all-red.
module intersection_scheduler #(
    parameter int unsigned GREEN_MIN = 8,
    parameter int unsigned GREEN_MAX = 20,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned WALK_T    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] state,
    output logic       ped_pending
);

    typedef enum logic [2:0] {
        S_NS_G  = 3'd0,
        S_NS_Y  = 3'd1,
        S_AR_NS = 3'd2,
        S_EW_G  = 3'd3,
        S_EW_Y  = 3'd4,
        S_AR_EW = 3'd5,
        S_WALK  = 3'd6,
        S_BAD   = 3'd7
    } state_t;

    // Terminal timer values: a state held N cycles ends when tmr == N-1.
    localparam logic [7:0] L_GMIN  = 8'(GREEN_MIN - 1);
    localparam logic [7:0] L_GMAX  = 8'(GREEN_MAX - 1);
    localparam logic [7:0] L_YEL   = 8'(YELLOW_T - 1);
    localparam logic [7:0] L_AR    = 8'(ALLRED_T - 1);
    localparam logic [7:0] L_WALK  = 8'(WALK_T - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_tmr;
    logic       r_ped;
    logic       r_last_ns;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_NS_G:  if ((r_tmr >= L_GMIN && (car_ew || r_ped)) || r_tmr == L_GMAX) w_next = S_NS_Y;
            S_NS_Y:  if (r_tmr == L_YEL) w_next = S_AR_NS;
            S_AR_NS: if (r_tmr == L_AR) w_next = r_ped ? S_WALK : S_EW_G;
            S_EW_G:  if ((r_tmr >= L_GMIN && (car_ns || r_ped)) || r_tmr == L_GMAX) w_next = S_EW_Y;
            S_EW_Y:  if (r_tmr == L_YEL) w_next = S_AR_EW;
            S_AR_EW: if (r_tmr == L_AR) w_next = r_ped ? S_WALK : S_NS_G;
            S_WALK:  if (r_tmr == L_WALK) w_next = r_last_ns ? S_EW_G : S_NS_G;
            default: w_next = S_AR_EW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_AR_EW;
            r_tmr     <= '0;
            r_ped     <= 1'b0;
            r_last_ns <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tmr   <= (w_next != r_state) ? '0 : r_tmr + 8'd1;
            if (r_state == S_NS_G && w_next != S_NS_G)
                r_last_ns <= 1'b1;
            else if (r_state == S_EW_G && w_next != S_EW_G)
                r_last_ns <= 1'b0;
            // Entering WALK consumes the request even if a new press arrives that cycle.
            if (w_next == S_WALK && r_state != S_WALK)
                r_ped <= 1'b0;
            else if (ped_req && r_state != S_WALK)
                r_ped <= 1'b1;
        end
    end

    always_comb begin
        ns_green    = (r_state == S_NS_G);
        ns_yellow   = (r_state == S_NS_Y);
        ew_green    = (r_state == S_EW_G);
        ew_yellow   = (r_state == S_EW_Y);
        ns_red      = !(ns_green || ns_yellow);
        ew_red      = !(ew_green || ew_yellow);
        walk        = (r_state == S_WALK);
        state       = r_state;
        ped_pending = r_ped;
    end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed scenario tests plus a randomized run against a phase/duration reference model.
module tb_intersection_scheduler;

    localparam int GMIN = 8;
    localparam int GMAX = 20;
    localparam int YEL  = 3;
    localparam int AR   = 2;
    localparam int WLK  = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       car_ns = 1'b0;
    logic       car_ew = 1'b0;
    logic       ped_req = 1'b0;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
    logic [2:0] state;
    logic       ped_pending;

    int checks = 0;
    int failures = 0;

    // reference model: phase number, cycles already spent in it, request latch, last green road
    int m_st;
    int m_age;
    bit m_ped;
    bit m_last;

    intersection_scheduler #(
        .GREEN_MIN(GMIN),
        .GREEN_MAX(GMAX),
        .YELLOW_T (YEL),
        .ALLRED_T (AR),
        .WALK_T   (WLK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .car_ns     (car_ns),
        .car_ew     (car_ew),
        .ped_req    (ped_req),
        .ns_red     (ns_red),
        .ns_yellow  (ns_yellow),
        .ns_green   (ns_green),
        .ew_red     (ew_red),
        .ew_yellow  (ew_yellow),
        .ew_green   (ew_green),
        .walk       (walk),
        .state      (state),
        .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // number of consecutive samples spent in state s (bounded)
    task automatic measure(input logic [2:0] s, output int n);
        n = 0;
        while (state === s && n < 300) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        car_ns = 0; car_ew = 0; ped_req = 0;
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} !== 7'b1001000) begin
            failures++;
            $display("FAIL reset_lamps got=%b want=1001000",
                     {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk});
        end
        checks++;
        if (state !== 3'd5 || ped_pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got state=%0d ped=%b want state=5 ped=0", state, ped_pending);
        end
        reset = 1'b0;
    endtask

    task automatic test_no_demand();
        int n;
        measure(3'd5, n);
        checks++; if (n !== AR)   begin failures++; $display("FAIL nd_ar_ew got=%0d want=%0d", n, AR); end
        measure(3'd0, n);
        checks++; if (n !== GMAX) begin failures++; $display("FAIL nd_ns_g got=%0d want=%0d", n, GMAX); end
        measure(3'd1, n);
        checks++; if (n !== YEL)  begin failures++; $display("FAIL nd_ns_y got=%0d want=%0d", n, YEL); end
        measure(3'd2, n);
        checks++; if (n !== AR)   begin failures++; $display("FAIL nd_ar_ns got=%0d want=%0d", n, AR); end
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL nd_to_ew got=%0d want=3", state); end
    endtask

    task automatic test_car_ew();
        int n;
        car_ew = 1; car_ns = 0; ped_req = 0;
        apply_reset();
        measure(3'd5, n);
        for (int unsigned k = 0; k < 2; k++) begin
            measure(3'd0, n);
            checks++; if (n !== GMIN) begin failures++; $display("FAIL ce_ns_g got=%0d want=%0d", n, GMIN); end
            measure(3'd1, n);
            measure(3'd2, n);
            measure(3'd3, n);
            checks++; if (n !== GMAX) begin failures++; $display("FAIL ce_ew_g got=%0d want=%0d", n, GMAX); end
            measure(3'd4, n);
            checks++; if (n !== YEL)  begin failures++; $display("FAIL ce_ew_y got=%0d want=%0d", n, YEL); end
            measure(3'd5, n);
            checks++; if (n !== AR)   begin failures++; $display("FAIL ce_ar_ew got=%0d want=%0d", n, AR); end
        end
        car_ew = 0;
    endtask

    task automatic test_ped();
        int n;
        car_ns = 0; car_ew = 0; ped_req = 0;
        apply_reset();
        measure(3'd5, n);
        tick(); tick();             // now in NS_G with tmr=2
        ped_req = 1;
        tick();
        ped_req = 0;
        checks++; if (ped_pending !== 1'b1) begin failures++; $display("FAIL ped_latch got=%b want=1", ped_pending); end
        measure(3'd0, n);           // tmr 3..7 remain
        checks++; if (n !== GMIN - 3) begin failures++; $display("FAIL ped_ns_g_rest got=%0d want=%0d", n, GMIN - 3); end
        measure(3'd1, n);
        checks++; if (n !== YEL) begin failures++; $display("FAIL ped_ns_y got=%0d want=%0d", n, YEL); end
        measure(3'd2, n);
        checks++; if (n !== AR) begin failures++; $display("FAIL ped_ar_ns got=%0d want=%0d", n, AR); end
        n = 0;
        while (state === 3'd6 && n < 300) begin
            checks++;
            if ({walk, ns_red, ew_red, ped_pending} !== 4'b1110) begin
                failures++;
                $display("FAIL ped_walk_lamps got=%b want=1110", {walk, ns_red, ew_red, ped_pending});
            end
            n++;
            tick();
        end
        checks++; if (n !== WLK) begin failures++; $display("FAIL ped_walk_len got=%0d want=%0d", n, WLK); end
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL ped_after_walk got=%0d want=3", state); end
    endtask

    task automatic test_ped_held();
        int n;
        car_ns = 0; car_ew = 0;
        apply_reset();
        ped_req = 1;
        measure(3'd5, n);
        checks++; if (state !== 3'd6) begin failures++; $display("FAIL held_walk_entry got=%0d want=6", state); end
        n = 0;
        while (state === 3'd6 && n < 300) begin
            checks++;
            if (ped_pending !== 1'b0) begin failures++; $display("FAIL held_ped_in_walk got=%b want=0", ped_pending); end
            n++;
            tick();
        end
        ped_req = 0;
        checks++; if (n !== WLK) begin failures++; $display("FAIL held_walk_len got=%0d want=%0d", n, WLK); end
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL held_exit got=%0d want=0", state); end
        tick();
        checks++; if (ped_pending !== 1'b0) begin failures++; $display("FAIL held_no_relatch got=%b want=0", ped_pending); end
        measure(3'd0, n);
        checks++; if (n !== GMAX - 1) begin failures++; $display("FAIL held_ns_g got=%0d want=%0d", n, GMAX - 1); end
        measure(3'd1, n);
        measure(3'd2, n);
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL held_no_second_walk got=%0d want=3", state); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit pulsed;
        car_ns = 0; car_ew = 0; ped_req = 0;
        apply_reset();
        n = 0;
        pulsed = 0;
        while (state !== 3'd4 && n < 300) begin
            ped_req = (state === 3'd3 && !pulsed);
            if (state === 3'd3) pulsed = 1;
            n++;
            tick();
        end
        ped_req = 0;
        tick();                     // EW_Y tmr=1
        checks++;
        if (state !== 3'd4 || ped_pending !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup got state=%0d ped=%b want state=4 ped=1", state, ped_pending);
        end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if ({state, ns_red, ew_red, ped_pending, walk, ew_yellow} !== 8'b101_11000) begin
            failures++;
            $display("FAIL mid_reset got=%b want=10111000",
                     {state, ns_red, ew_red, ped_pending, walk, ew_yellow});
        end
        measure(3'd5, n);
        checks++; if (n !== AR) begin failures++; $display("FAIL mid_ar_ew got=%0d want=%0d", n, AR); end
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL mid_to_ns_g got=%0d want=0", state); end
    endtask

    function automatic int fixed_len(input int st);
        case (st)
            1, 4:    return YEL;
            2, 5:    return AR;
            default: return WLK;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit pr, input bit cn, input bit ce);
        int done;
        int nxt;
        if (rst) begin
            m_st = 5; m_age = 0; m_ped = 0; m_last = 0;
            return;
        end
        done = m_age + 1;
        nxt = m_st;
        case (m_st)
            0: if (done == GMAX || (done >= GMIN && (ce || m_ped))) nxt = 1;
            3: if (done == GMAX || (done >= GMIN && (cn || m_ped))) nxt = 4;
            default:
                if (done == fixed_len(m_st)) begin
                    case (m_st)
                        1:       nxt = 2;
                        4:       nxt = 5;
                        2:       nxt = m_ped ? 6 : 3;
                        5:       nxt = m_ped ? 6 : 0;
                        default: nxt = m_last ? 3 : 0;
                    endcase
                end
        endcase
        if (nxt == 6 && m_st != 6) m_ped = 0;
        else if (pr && m_st != 6)  m_ped = 1;
        if (m_st == 0 && nxt != 0) m_last = 1;
        if (m_st == 3 && nxt != 3) m_last = 0;
        m_age = (nxt == m_st) ? done : 0;
        m_st = nxt;
    endtask

    task automatic test_random();
        bit rst, pr, cn, ce;
        logic [6:0] exp_l;
        cn = 0; ce = 0;
        car_ns = 0; car_ew = 0; ped_req = 0;
        apply_reset();
        model_step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            exp_l = {!(m_st == 0 || m_st == 1), m_st == 1, m_st == 0,
                     !(m_st == 3 || m_st == 4), m_st == 4, m_st == 3, m_st == 6};
            checks++;
            if (state !== 3'(m_st) || ped_pending !== m_ped) begin
                failures++;
                $display("FAIL rnd_state cyc=%0d got state=%0d ped=%b want state=%0d ped=%b",
                         i, state, ped_pending, m_st, m_ped);
            end
            checks++;
            if ({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} !== exp_l) begin
                failures++;
                $display("FAIL rnd_lamps cyc=%0d got=%b want=%b", i,
                         {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}, exp_l);
            end
            checks++;
            if ((ns_red + ns_yellow + ns_green) != 1 || (ew_red + ew_yellow + ew_green) != 1 ||
                (walk && (ns_green || ns_yellow || ew_green || ew_yellow))) begin
                failures++;
                $display("FAIL rnd_invariant cyc=%0d got=%b", i,
                         {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk});
            end
            rst = ($urandom_range(0, 999) == 0);
            pr  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) cn = !cn;
            if ($urandom_range(0, 15) == 0) ce = !ce;
            reset = rst; ped_req = pr; car_ns = cn; car_ew = ce;
            tick();
            model_step(rst, pr, cn, ce);
        end
        reset = 0; ped_req = 0; car_ns = 0; car_ew = 0;
    endtask

    initial begin
        test_reset();
        test_no_demand();
        test_car_ew();
        test_ped();
        test_ped_held();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
